bus_router: RTL and testbench
=============================

Name: bus_router

Overview:
- Single-master bus stage directly downstream of memory_map.
- Accepts one CPU load/store at a time and registers the one-hot device select produced by memory_map for the latched address.
- Forwards the request to exactly one slave, waits for that slave's completion, then returns read data or an error to the CPU.
- Adds a timeout so a hung peripheral cannot stall the core forever.

Parameters:
- N_SLAVES, 9, number of slave ports; index order is fixed as 0 bootloader, 1 sdram, 2 gpu, 3 ps2, 4 gpio, 5 hex, 6 test, 7 sd_card, 8 xv6.
- TIMEOUT_CYCLES, 1023, maximum WAIT cycles before the transaction completes with an error; minimum legal value 2.
- ERR_RDATA, 32'h00000000, value driven on o_rdata for an errored read.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous, active-high reset.
- i_req  in  1  CPU request strobe; accepted when i_req && o_ready.
- i_addr  in  32  byte address.
- i_wdata  in  32  write data.
- i_we  in  1  1 = write, 0 = read.
- i_be  in  4  byte enables.
- o_ready  out  1  high only in IDLE.
- o_done  out  1  one-cycle completion pulse.
- o_rdata  out  32  read data; valid only while o_done is high.
- o_error  out  1  valid with o_done; set for unmapped address or timeout.
- o_slave_req  out  N_SLAVES  one-hot, one-cycle start pulse to the selected slave.
- o_addr  out  32  latched address, broadcast to all slaves.
- o_wdata  out  32  latched write data.
- o_we  out  1  latched write flag.
- o_be  out  4  latched byte enables.
- i_slave_done  in  N_SLAVES  per-slave completion pulse.
- i_slave_rdata  in  32*N_SLAVES  packed read data; slave k occupies bits [32k+31:32k].

Behaviour:
- Reset: state IDLE, o_ready=1, o_done=0, o_error=0, o_rdata=0, o_slave_req=0, o_addr/o_wdata/o_we/o_be=0, select register=0, timeout counter=0.
- Reset asserted mid-transaction drops to IDLE in the next cycle. Any in-flight slave access is abandoned and no o_done is produced.
- FSM states: IDLE, DECODE, ISSUE, WAIT, RESP.
- IDLE: if i_req, latch addr/wdata/we/be into the o_* registers and go to DECODE. i_req is ignored in every other state.
- DECODE: register the memory_map DV outputs (driven from the latched address) into the one-hot select.
  - Select all-zero: go to RESP with error=1, rdata=ERR_RDATA.
  - Otherwise go to ISSUE.
- ISSUE: o_slave_req = select for exactly one cycle; clear the counter; go to WAIT.
- WAIT: each cycle, sample i_slave_done & select.
  - On a hit: capture that slave's rdata slice, error=0, go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES-1 without a hit, go to RESP with error=1, rdata=ERR_RDATA.
  - Done pulses from non-selected slaves are ignored.
  - A hit in the same cycle as the timeout wins: error=0.
- RESP: o_done=1 for one cycle with o_rdata/o_error; go to IDLE. o_rdata returns to 0 the cycle after.
- o_addr/o_wdata/o_we/o_be stay stable from DECODE through RESP.
- Latency: with i_req accepted at cycle T, o_slave_req fires at T+2 and WAIT begins at T+3.
  - Slave done at T+3 gives o_done at T+4.
  - Unmapped address gives o_done at T+2.
- A back-to-back request is accepted at the earliest in the cycle after RESP, since o_ready is high only in IDLE.
- Writes complete through the same done handshake as reads; rdata is don't-care for writes but driven as captured.
- Address map boundaries follow memory_map exactly. Example unmapped addresses:
  - 0x00002000 in synthesis builds, but mapped to the bootloader under SIMULATION.
  - 0x80000000 without XV6.
  - 0x90000000 and above.

Decomposition:
- Shared package bus_pkg holds:
  - Slave index constants (SLV_BOOT=0 … SLV_XV6=8) and N_SLAVES.
  - FSM state encoding.
  - ERR_RDATA default.
- Sub-module: instantiate the existing memory_map as the decoder. The only other logic is a small onehot_mux (N_SLAVES×32 one-hot read-data select), which is a natural separate sub-module.

Test Plan:
- Read gpio: i_req with i_addr=0x40000010, i_we=0. Expect o_slave_req=9'b000010000 at T+2. Slave 4 returns done with rdata 0x000000A5 at T+5. Expect o_done=1, o_rdata=0x000000A5, o_error=0 at T+6.
- Write hex: i_addr=0x50000004, i_wdata=0x12345678, i_be=4'b0011, i_we=1. Expect a single o_slave_req[5] pulse and o_addr/o_wdata/o_be held until o_done. Slave done at T+3 gives o_done at T+4, error=0.
- Unmapped: i_addr=0x90000000 (and 0x00004000 in a non-SIMULATION build). Expect no o_slave_req, and o_done=1, o_error=1, o_rdata=0 at T+2.
- Timeout: TIMEOUT_CYCLES=8, sdram read at 0x10000000, slave never responds. Expect o_done with o_error=1 exactly 8 cycles after WAIT entry. A late done afterwards is ignored.
- Spurious done: during a gpu (0x20000000) access, pulse i_slave_done[3] with rdata 0xFFFFFFFF. Expect no completion. Then i_slave_done[2] with 0x0000BEEF gives o_rdata=0x0000BEEF.
- Reset mid-WAIT: assert i_rst for one cycle during WAIT. Next cycle expect o_ready=1 and all outputs at reset values, no o_done. A new request then completes normally.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared constants and types for the single-master bus stage: slave indices,
// FSM encoding and the default error read value.
package bus_pkg;

    localparam int N_SLAVES = 9;

    localparam int SLV_BOOT  = 0;
    localparam int SLV_SDRAM = 1;
    localparam int SLV_GPU   = 2;
    localparam int SLV_PS2   = 3;
    localparam int SLV_GPIO  = 4;
    localparam int SLV_HEX   = 5;
    localparam int SLV_TEST  = 6;
    localparam int SLV_SD    = 7;
    localparam int SLV_XV6   = 8;

    localparam logic [31:0] ERR_RDATA_DEF = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

endpackage

// File: rtl/memory_map.sv
// Address decoder: one-hot device-valid vector for a byte address. Each
// peripheral owns one 256 MiB region selected by the top address nibble.
module memory_map
    import bus_pkg::*;
#(
    parameter bit SIMULATION = 1'b0,
    parameter bit XV6_EN     = 1'b0
) (
    input  logic [31:0]         addr,
    output logic [N_SLAVES-1:0] dv
);

    // Simulation builds get a larger bootloader window for test images.
    localparam logic [27:0] BOOT_LIMIT = SIMULATION ? 28'h000_4000 : 28'h000_2000;

    // Region decode on the top nibble; the bootloader only covers its low window.
    always_comb begin
        dv = '0;
        case (addr[31:28])
            4'h0: begin
                if (addr[27:0] < BOOT_LIMIT) begin
                    dv[SLV_BOOT] = 1'b1;
                end else begin
                    dv = '0;
                end
            end
            4'h1: dv[SLV_SDRAM] = 1'b1;
            4'h2: dv[SLV_GPU]   = 1'b1;
            4'h3: dv[SLV_PS2]   = 1'b1;
            4'h4: dv[SLV_GPIO]  = 1'b1;
            4'h5: dv[SLV_HEX]   = 1'b1;
            4'h6: dv[SLV_TEST]  = 1'b1;
            4'h7: dv[SLV_SD]    = 1'b1;
            4'h8: begin
                if (XV6_EN) begin
                    dv[SLV_XV6] = 1'b1;
                end else begin
                    dv = '0;
                end
            end
            default: dv = '0;
        endcase
    end

endmodule

// File: rtl/onehot_mux.sv
// AND-OR selector for N packed W-bit words under a one-hot select; an
// all-zero select yields zero.
module onehot_mux #(
    parameter int N = 9,
    parameter int W = 32
) (
    input  logic [N-1:0]   sel,
    input  logic [N*W-1:0] data,
    output logic [W-1:0]   dout
);

    // OR together every word whose select bit is set.
    always_comb begin
        dout = '0;
        for (int k = 0; k < N; k++) begin
            dout = dout | ({W{sel[k]}} & data[k*W +: W]);
        end
    end

endmodule

// File: rtl/bus_router.sv
// Single-master bus stage: latches one CPU access, starts exactly one slave,
// waits for its done (with timeout) and returns read data or an error.
module bus_router
    import bus_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 1023,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEF,
    parameter bit          SIMULATION     = 1'b0,
    parameter bit          XV6_EN         = 1'b0
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_req,
    input  logic [31:0]            i_addr,
    input  logic [31:0]            i_wdata,
    input  logic                   i_we,
    input  logic [3:0]             i_be,
    output logic                   o_ready,
    output logic                   o_done,
    output logic [31:0]            o_rdata,
    output logic                   o_error,
    output logic [N_SLAVES-1:0]    o_slave_req,
    output logic [31:0]            o_addr,
    output logic [31:0]            o_wdata,
    output logic                   o_we,
    output logic [3:0]             o_be,
    input  logic [N_SLAVES-1:0]    i_slave_done,
    input  logic [32*N_SLAVES-1:0] i_slave_rdata
);

    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t              state_r;
    logic [N_SLAVES-1:0] sel_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [N_SLAVES-1:0] dv_s;
    logic [31:0]         mux_rdata_s;
    logic                hit_s;

    memory_map #(
        .SIMULATION (SIMULATION),
        .XV6_EN     (XV6_EN)
    ) u_memory_map (
        .addr (o_addr),
        .dv   (dv_s)
    );

    onehot_mux #(
        .N (N_SLAVES),
        .W (32)
    ) u_rdata_mux (
        .sel  (sel_r),
        .data (i_slave_rdata),
        .dout (mux_rdata_s)
    );

    // Done pulses from slaves other than the selected one never count.
    assign hit_s = |(i_slave_done & sel_r);

    // Transaction FSM; every output is a register set on the transition into the state that owns it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r     <= ST_IDLE;
            sel_r       <= '0;
            cnt_r       <= '0;
            o_ready     <= 1'b1;
            o_done      <= 1'b0;
            o_rdata     <= 32'h0000_0000;
            o_error     <= 1'b0;
            o_slave_req <= '0;
            o_addr      <= 32'h0000_0000;
            o_wdata     <= 32'h0000_0000;
            o_we        <= 1'b0;
            o_be        <= 4'h0;
        end else begin
            o_slave_req <= '0;
            o_done      <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (i_req) begin
                        o_addr  <= i_addr;
                        o_wdata <= i_wdata;
                        o_we    <= i_we;
                        o_be    <= i_be;
                        o_ready <= 1'b0;
                        state_r <= ST_DECODE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_DECODE: begin
                    sel_r <= dv_s;
                    if (dv_s == '0) begin
                        o_done  <= 1'b1;
                        o_error <= 1'b1;
                        o_rdata <= ERR_RDATA;
                        state_r <= ST_RESP;
                    end else begin
                        o_slave_req <= dv_s;
                        state_r     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt_r   <= '0;
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A hit on the final timeout cycle still completes cleanly.
                    if (hit_s) begin
                        o_done  <= 1'b1;
                        o_error <= 1'b0;
                        o_rdata <= mux_rdata_s;
                        state_r <= ST_RESP;
                    end else if (cnt_r == CNT_LAST) begin
                        o_done  <= 1'b1;
                        o_error <= 1'b1;
                        o_rdata <= ERR_RDATA;
                        state_r <= ST_RESP;
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
                        state_r <= ST_WAIT;
                    end
                end
                ST_RESP: begin
                    o_rdata <= 32'h0000_0000;
                    o_error <= 1'b0;
                    o_ready <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    o_ready <= 1'b1;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_router.sv
// Directed bench for bus_router: a transaction-level model fills per-cycle
// expectations from the latency/decode rules; one process compares every cycle.
module tb_bus_router;

    localparam int TO   = 8;
    localparam int NS   = 9;
    localparam int MAXC = 1024;

    logic          clk = 1'b0;
    logic          i_rst, i_req, i_we;
    logic [31:0]   i_addr, i_wdata;
    logic [3:0]    i_be;
    logic          o_ready, o_done, o_error, o_we;
    logic [31:0]   o_rdata, o_addr, o_wdata;
    logic [3:0]    o_be;
    logic [NS-1:0] o_slave_req, i_slave_done;
    logic [32*NS-1:0] i_slave_rdata;

    always #5 clk = ~clk;

    bus_router #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_req(i_req), .i_addr(i_addr),
        .i_wdata(i_wdata), .i_we(i_we), .i_be(i_be), .o_ready(o_ready),
        .o_done(o_done), .o_rdata(o_rdata), .o_error(o_error),
        .o_slave_req(o_slave_req), .o_addr(o_addr), .o_wdata(o_wdata),
        .o_we(o_we), .o_be(o_be), .i_slave_done(i_slave_done),
        .i_slave_rdata(i_slave_rdata)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    // Per-cycle expectations written by the transaction model.
    logic          exp_ready [MAXC];
    logic          exp_done  [MAXC];
    logic          exp_err   [MAXC];
    logic          exp_hold  [MAXC];
    logic          exp_zero  [MAXC];
    logic [31:0]   exp_rdata [MAXC];
    logic [31:0]   exp_addr  [MAXC];
    logic [31:0]   exp_wdata [MAXC];
    logic          exp_we    [MAXC];
    logic [3:0]    exp_be    [MAXC];
    logic [NS-1:0] exp_sreq  [MAXC];
    bit            chk_en = 1'b0;

    int            last_done_cyc = -1;
    int            last_sreq_cyc = -1;
    logic [31:0]   last_rdata = 32'h0;
    logic          last_err = 1'b0;
    logic [NS-1:0] last_sreq = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Slave index for an address, or -1 when unmapped (synthesis build, no XV6).
    function automatic int ref_decode(input logic [31:0] a);
        if (a < 32'h0000_2000) return 0;
        if (a >= 32'h1000_0000 && a < 32'h8000_0000) return int'(a[31:28]);
        return -1;
    endfunction

    always @(negedge clk) begin
        if (chk_en && cyc < MAXC) begin
            chk("ready", 32'(o_ready), 32'(exp_ready[cyc]));
            chk("done", 32'(o_done), 32'(exp_done[cyc]));
            chk("slave_req", 32'(o_slave_req), 32'(exp_sreq[cyc]));
            if (exp_done[cyc]) begin
                chk("rdata", o_rdata, exp_rdata[cyc]);
                chk("error", 32'(o_error), 32'(exp_err[cyc]));
            end else begin
                chk("rdata_idle", o_rdata, 32'h0);
            end
            if (exp_hold[cyc]) begin
                chk("addr_hold", o_addr, exp_addr[cyc]);
                chk("wdata_hold", o_wdata, exp_wdata[cyc]);
                chk("we_hold", 32'(o_we), 32'(exp_we[cyc]));
                chk("be_hold", 32'(o_be), 32'(exp_be[cyc]));
            end
            if (exp_zero[cyc]) begin
                chk("rst_addr", o_addr, 32'h0);
                chk("rst_wdata", o_wdata, 32'h0);
                chk("rst_we", 32'(o_we), 32'h0);
                chk("rst_be", 32'(o_be), 32'h0);
                chk("rst_error", 32'(o_error), 32'h0);
            end
        end
        if (o_done) begin
            last_done_cyc = cyc;
            last_rdata    = o_rdata;
            last_err      = o_error;
        end
        if (o_slave_req != '0) begin
            last_sreq_cyc = cyc;
            last_sreq     = o_slave_req;
        end
    end

    // Called and returning at a negedge; offsets resp_d/spur_d/rst_d count from WAIT entry (-1 = none).
    task automatic txn(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                       input logic [3:0] be, input int resp_d, input logic [31:0] rdata,
                       input int spur_d, input int spur_idx, input int rst_d, output int t0);
        int idx, w, done_c, resp_c, spur_c, rst_c, last_c, end_c;
        logic eerr;
        logic [31:0] erd;
        t0  = cyc;
        idx = ref_decode(addr);
        w   = t0 + 3;
        i_req = 1'b1; i_addr = addr; i_wdata = wdata; i_we = we; i_be = be;
        resp_c = (idx >= 0 && resp_d >= 0) ? w + resp_d : -1;
        spur_c = (idx >= 0 && spur_d >= 0) ? w + spur_d : -1;
        rst_c  = (idx >= 0 && rst_d >= 0) ? w + rst_d : -1;
        if (idx < 0) begin
            done_c = t0 + 2; eerr = 1'b1; erd = 32'h0;
        end else if (resp_d >= 0 && resp_d < TO) begin
            done_c = w + resp_d + 1; eerr = 1'b0; erd = rdata;
        end else begin
            done_c = w + TO; eerr = 1'b1; erd = 32'h0;
        end
        if (idx >= 0) exp_sreq[t0 + 2] = NS'(1) << idx;
        last_c = (rst_c >= 0) ? rst_c : done_c;
        for (int c = t0 + 1; c <= last_c; c++) begin
            exp_ready[c] = 1'b0; exp_hold[c] = 1'b1;
            exp_addr[c] = addr; exp_wdata[c] = wdata; exp_we[c] = we; exp_be[c] = be;
        end
        if (rst_c >= 0) begin
            exp_zero[rst_c + 1] = 1'b1;
        end else begin
            exp_done[done_c] = 1'b1; exp_err[done_c] = eerr; exp_rdata[done_c] = erd;
        end
        end_c = last_c;
        if (resp_c > end_c) end_c = resp_c;
        if (spur_c > end_c) end_c = spur_c;
        if (rst_c >= 0 && rst_c + 1 > end_c) end_c = rst_c + 1;
        while (cyc <= end_c) begin
            @(negedge clk);
            // A competing request while busy must be ignored.
            if (cyc == t0 + 1) begin
                i_req = 1'b1; i_addr = 32'h4000_0000; i_wdata = ~wdata; i_we = ~we; i_be = ~be;
            end else begin
                i_req = 1'b0;
            end
            i_slave_done = '0;
            for (int k = 0; k < NS; k++)
                i_slave_rdata[k*32 +: 32] = 32'hDEAD_0000 + 32'(k * 256 + (cyc & 255));
            if (cyc == resp_c) begin
                i_slave_done[idx] = 1'b1; i_slave_rdata[idx*32 +: 32] = rdata;
            end
            if (cyc == spur_c) begin
                i_slave_done[spur_idx] = 1'b1; i_slave_rdata[spur_idx*32 +: 32] = 32'hFFFF_FFFF;
            end
            i_rst = (cyc == rst_c);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t;
        for (int c = 0; c < MAXC; c++) begin
            exp_ready[c] = 1'b1; exp_done[c] = 1'b0; exp_err[c] = 1'b0; exp_hold[c] = 1'b0;
            exp_zero[c] = 1'b0; exp_rdata[c] = 32'h0; exp_addr[c] = 32'h0; exp_wdata[c] = 32'h0;
            exp_we[c] = 1'b0; exp_be[c] = 4'h0; exp_sreq[c] = '0;
        end
        i_rst = 1'b1; i_req = 1'b0; i_addr = 32'h0; i_wdata = 32'h0; i_we = 1'b0; i_be = 4'h0;
        i_slave_done = '0; i_slave_rdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(o_ready), 32'h1);
        chk("reset_done", 32'(o_done), 32'h0);
        chk("reset_sreq", 32'(o_slave_req), 32'h0);
        chk("reset_rdata", o_rdata, 32'h0);
        i_rst = 1'b0;
        exp_zero[cyc + 1] = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        // gpio read, slave answers two cycles into WAIT
        txn(32'h4000_0010, 32'h0, 1'b0, 4'hF, 2, 32'h0000_00A5, -1, 0, -1, t);
        chk("gpio_sreq", 32'(last_sreq), 32'h0000_0010);
        chk("gpio_sreq_lat", 32'(last_sreq_cyc - t), 32'd2);
        chk("gpio_done_lat", 32'(last_done_cyc - t), 32'd6);
        chk("gpio_rdata", last_rdata, 32'h0000_00A5);
        // hex write, back-to-back
        txn(32'h5000_0004, 32'h1234_5678, 1'b1, 4'b0011, 0, 32'h0, -1, 0, -1, t);
        chk("hex_done_lat", 32'(last_done_cyc - t), 32'd4);
        chk("hex_error", 32'(last_err), 32'h0);
        // unmapped addresses
        txn(32'h9000_0000, 32'h0, 1'b0, 4'hF, 0, 32'h0, -1, 0, -1, t);
        chk("unmapped_done_lat", 32'(last_done_cyc - t), 32'd2);
        chk("unmapped_error", 32'(last_err), 32'h1);
        txn(32'h0000_4000, 32'h0, 1'b0, 4'hF, 0, 32'h0, -1, 0, -1, t);
        txn(32'h0000_2000, 32'h0, 1'b1, 4'h1, 0, 32'h0, -1, 0, -1, t);
        txn(32'h8000_0000, 32'h0, 1'b0, 4'hF, 0, 32'h0, -1, 0, -1, t);
        txn(32'hFFFF_FFFC, 32'h0, 1'b0, 4'hF, 0, 32'h0, -1, 0, -1, t);
        // sdram timeout, then a late done that must be ignored
        txn(32'h1000_0000, 32'h0, 1'b0, 4'hF, 10, 32'h1111_1111, -1, 0, -1, t);
        chk("timeout_done_lat", 32'(last_done_cyc - t), 32'd11);
        chk("timeout_error", 32'(last_err), 32'h1);
        // hit on the last timeout cycle wins
        txn(32'h1000_0040, 32'h0, 1'b0, 4'hF, TO - 1, 32'h1357_9BDF, -1, 0, -1, t);
        chk("edge_hit_error", 32'(last_err), 32'h0);
        // spurious done from ps2 during a gpu access
        txn(32'h2000_0000, 32'h0, 1'b0, 4'hF, 3, 32'h0000_BEEF, 1, 3, -1, t);
        chk("spurious_rdata", last_rdata, 32'h0000_BEEF);
        // remaining slaves, including the top of the bootloader window
        txn(32'h0000_1FFC, 32'h0, 1'b0, 4'hF, 0, 32'hB007_0001, -1, 0, -1, t);
        txn(32'h3000_0008, 32'h0, 1'b0, 4'hF, 1, 32'h0000_0033, -1, 0, -1, t);
        txn(32'h6000_0000, 32'hCAFE_F00D, 1'b1, 4'b1100, 4, 32'h0, -1, 0, -1, t);
        // reset during WAIT, then a normal access
        txn(32'h4000_0020, 32'h0, 1'b0, 4'hF, -1, 32'h0, -1, 0, 2, t);
        txn(32'h7000_0008, 32'h0, 1'b0, 4'hF, 1, 32'h5D5D_0007, -1, 0, -1, t);
        chk("after_reset_rdata", last_rdata, 32'h5D5D_0007);
        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
